pio_bank: RTL and testbench

PIO_BANK -- requirements
Module: pio_bank

---
 rtl/pio_bank.sv | 146 ++++++++++++++
 tb/tb_pio_bank.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_bank.sv
// Memory-mapped parallel I/O bank with output registers, synchronized input channels and edge interrupts.
// Define PIO_DEBOUNCE_EN to add a per-channel stability filter in front of the IN registers.
module pio_bank #(
    parameter int DATA_W     = 32,
    parameter int N_OUT      = 4,
    parameter int N_IN       = 2,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic [N_OUT*DATA_W-1:0] out_port,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic                    irq
);

    localparam logic [4:0] IN_BASE   = 5'h10;
    localparam logic [4:0] MASK_BASE = 5'h14;
    localparam logic [4:0] EDGE_BASE = 5'h18;
    localparam logic [4:0] CTRL_ADDR = 5'h1F;

    logic [DATA_W-1:0]      out_reg  [N_OUT];
    logic [DATA_W-1:0]      mask_reg [N_IN];
    logic [DATA_W-1:0]      edge_reg [N_IN];
    logic [DATA_W-1:0]      in_val   [N_IN];
    logic [DATA_W-1:0]      prev_val [N_IN];
    logic [DATA_W-1:0]      edge_set [N_IN];
    logic [DATA_W-1:0]      edge_clr [N_IN];
    logic [N_IN*DATA_W-1:0] sync1;
    logic [N_IN*DATA_W-1:0] sync2;
    logic                   rise_en;
    logic                   fall_en;
    logic [31:0]            rd_mux;
    logic                   irq_next;

    if (DEB_CYCLES < 2) begin : g_deb_cycles_invalid
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = out_reg[g];
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_OUT; i++)
            if (avs_address == 5'(i)) rd_mux[DATA_W-1:0] = out_reg[i];
        for (int i = 0; i < N_IN; i++) begin
            if (avs_address == IN_BASE + 5'(i))   rd_mux[DATA_W-1:0] = in_val[i];
            if (avs_address == MASK_BASE + 5'(i)) rd_mux[DATA_W-1:0] = mask_reg[i];
            if (avs_address == EDGE_BASE + 5'(i)) rd_mux[DATA_W-1:0] = edge_reg[i];
        end
        if (avs_address == CTRL_ADDR) rd_mux[1:0] = {fall_en, rise_en};
    end

    // A new edge in the same cycle as a write-1-to-clear keeps the bit set.
    always_comb begin
        irq_next = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            edge_set[i] = (rise_en ? (in_val[i] & ~prev_val[i]) : '0)
                        | (fall_en ? (~in_val[i] & prev_val[i]) : '0);
            edge_clr[i] = (avs_write && avs_address == EDGE_BASE + 5'(i))
                        ? avs_writedata[DATA_W-1:0] : '0;
            irq_next    = irq_next | (|(edge_reg[i] & mask_reg[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) out_reg[i] <= '0;
            for (int i = 0; i < N_IN; i++) begin
                mask_reg[i] <= '0;
                edge_reg[i] <= '0;
                prev_val[i] <= '0;
            end
            sync1             <= '0;
            sync2             <= '0;
            rise_en           <= 1'b0;
            fall_en           <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            sync1             <= in_port;
            sync2             <= sync1;
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_mux : '0;
            irq               <= irq_next;
            for (int i = 0; i < N_IN; i++) begin
                prev_val[i] <= in_val[i];
                edge_reg[i] <= (edge_reg[i] & ~edge_clr[i]) | edge_set[i];
            end
            if (avs_write) begin
                for (int i = 0; i < N_OUT; i++)
                    if (avs_address == 5'(i)) out_reg[i] <= avs_writedata[DATA_W-1:0];
                for (int i = 0; i < N_IN; i++)
                    if (avs_address == MASK_BASE + 5'(i)) mask_reg[i] <= avs_writedata[DATA_W-1:0];
                if (avs_address == CTRL_ADDR) begin
                    rise_en <= avs_writedata[0];
                    fall_en <= avs_writedata[1];
                end
            end
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [CNT_W-1:0]  deb_cnt   [N_IN];
    logic [DATA_W-1:0] sync_last [N_IN];

    // IN only follows the synced vector after it has stayed unchanged for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                in_val[i]    <= '0;
                deb_cnt[i]   <= '0;
                sync_last[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                sync_last[i] <= sync2[i*DATA_W +: DATA_W];
                if (sync2[i*DATA_W +: DATA_W] == in_val[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != '0 && sync2[i*DATA_W +: DATA_W] != sync_last[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    in_val[i]  <= sync2[i*DATA_W +: DATA_W];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N_IN; i++) in_val[i] = sync2[i*DATA_W +: DATA_W];
    end
`endif

endmodule

// File: tb/tb_pio_bank.sv
// Self-checking bench for pio_bank: register map, read timing, edge capture/irq and a randomized
// comparison against a delay-line model of the input path (debounce scenarios when PIO_DEBOUNCE_EN).
module tb_pio_bank;

    localparam int DW  = 32;
    localparam int NO  = 4;
    localparam int NI  = 2;
    localparam int DEB = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [4:0]        avs_address = '0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [NO*DW-1:0]  out_port;
    logic [NI*DW-1:0]  in_port = '0;
    logic              irq;

    int passed = 0;
    int total  = 0;
    logic [31:0] m_out [NO];

    pio_bank #(.DATA_W(DW), .N_OUT(NO), .N_IN(NI), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .out_port(out_port), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
        avs_address = a; avs_read = 1'b1;
        tick();
        d = avs_readdata; v = avs_readdatavalid;
        avs_read = 1'b0;
    endtask

    function automatic logic [NO*DW-1:0] packed_out();
        logic [NO*DW-1:0] p;
        for (int i = 0; i < NO; i++) p[i*DW +: DW] = m_out[i];
        return p;
    endfunction

    task automatic test_reset;
        logic [31:0] d; logic v;
        reset = 1'b1; in_port = '0;
        tick(); tick();
        total++; if (out_port !== '0) $display("[TB] FAIL reset_out: got %h want 0", out_port); else passed++;
        total++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b want 0", irq); else passed++;
        total++; if ({avs_readdatavalid, avs_readdata} !== 33'd0)
            $display("[TB] FAIL reset_rd: got %b/%h want 0/0", avs_readdatavalid, avs_readdata); else passed++;
        reset = 1'b0;
        tick();
        for (int i = 0; i < NO; i++) m_out[i] = '0;
        bus_read(5'h00, d, v);
        total++; if (d !== 32'h0 || v !== 1'b1) $display("[TB] FAIL reset_out0: got %h/%b want 0/1", d, v); else passed++;
        bus_read(5'h1F, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h want 0", d); else passed++;
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL reset_edge: got %h want 0", d); else passed++;
    endtask

    task automatic test_out_regs;
        logic [31:0] d; logic v; int a; logic [31:0] val;
        bus_write(5'h02, 32'h0000_00A5); m_out[2] = 32'hA5;
        total++; if (out_port[2*DW +: DW] !== 32'hA5)
            $display("[TB] FAIL out2_port: got %h want a5", out_port[2*DW +: DW]); else passed++;
        bus_read(5'h02, d, v);
        total++; if (d !== 32'hA5 || v !== 1'b1) $display("[TB] FAIL out2_read: got %h/%b want a5/1", d, v); else passed++;
        tick();
        total++; if (avs_readdata !== 32'h0 || avs_readdatavalid !== 1'b0)
            $display("[TB] FAIL rd_idle: got %h/%b want 0/0", avs_readdata, avs_readdatavalid); else passed++;
        for (int n = 0; n < 10; n++) begin
            a = $urandom_range(0, NO-1); val = $urandom;
            bus_write(5'(a), val); m_out[a] = val;
            total++; if (out_port !== packed_out()) $display("[TB] FAIL out_rand: got %h want %h", out_port, packed_out()); else passed++;
            a = $urandom_range(0, NO-1);
            bus_read(5'(a), d, v);
            total++; if (d !== m_out[a]) $display("[TB] FAIL out_read_rand: got %h want %h", d, m_out[a]); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        avs_read = 1'b1; avs_address = 5'h00;
        tick();
        avs_address = 5'h01;
        total++; if (avs_readdata !== m_out[0] || avs_readdatavalid !== 1'b1)
            $display("[TB] FAIL b2b_first: got %h want %h", avs_readdata, m_out[0]); else passed++;
        tick();
        avs_read = 1'b0;
        total++; if (avs_readdata !== m_out[1] || avs_readdatavalid !== 1'b1)
            $display("[TB] FAIL b2b_second: got %h want %h", avs_readdata, m_out[1]); else passed++;
        tick();
        total++; if (avs_readdatavalid !== 1'b0) $display("[TB] FAIL b2b_valid_drop: got %b want 0", avs_readdatavalid); else passed++;
    endtask

    task automatic test_unmapped;
        logic [31:0] d; logic v;
        logic [4:0] addrs [8] = '{5'h0F, 5'h1D, 5'h1C, 5'h1E, 5'h12, 5'h16, 5'h1A, 5'h04};
        foreach (addrs[k]) bus_write(addrs[k], 32'hFFFF_FFFF);
        total++; if (out_port !== packed_out()) $display("[TB] FAIL unmapped_write: got %h want %h", out_port, packed_out()); else passed++;
        foreach (addrs[k]) begin
            bus_read(addrs[k], d, v);
            total++; if (d !== 32'h0 || v !== 1'b1)
                $display("[TB] FAIL unmapped_read %h: got %h/%b want 0/1", addrs[k], d, v); else passed++;
        end
    endtask

    task automatic test_rw_collision;
        logic [31:0] d; logic v; logic [31:0] nv;
        nv = $urandom;
        avs_address = 5'h01; avs_writedata = nv; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        total++; if (avs_readdata !== m_out[1]) $display("[TB] FAIL rw_old: got %h want %h", avs_readdata, m_out[1]); else passed++;
        m_out[1] = nv;
        bus_read(5'h01, d, v);
        total++; if (d !== nv) $display("[TB] FAIL rw_new: got %h want %h", d, nv); else passed++;
    endtask

    task automatic test_mask_ctrl;
        logic [31:0] d; logic v; logic [31:0] mk [NI];
        for (int i = 0; i < NI; i++) begin mk[i] = $urandom; bus_write(5'h14 + 5'(i), mk[i]); end
        for (int i = 0; i < NI; i++) begin
            bus_read(5'h14 + 5'(i), d, v);
            total++; if (d !== mk[i]) $display("[TB] FAIL mask_rb%0d: got %h want %h", i, d, mk[i]); else passed++;
        end
        bus_write(5'h1F, 32'hFFFF_FFFF);
        bus_read(5'h1F, d, v);
        total++; if (d !== 32'h3) $display("[TB] FAIL ctrl_rb: got %h want 3", d); else passed++;
        bus_write(5'h1F, 32'h0);
        for (int i = 0; i < NI; i++) bus_write(5'h14 + 5'(i), 32'h0);
    endtask

    task automatic test_rise_irq;
        logic [31:0] d; logic v;
        bus_write(5'h1F, 32'h1);
        bus_write(5'h14, 32'h1);
        in_port[0] = 1'b1;
        tick(); tick();
        total++; if (irq !== 1'b0) $display("[TB] FAIL irq_early: got %b want 0", irq); else passed++;
        avs_address = 5'h18; avs_read = 1'b1;
        tick();
        total++; if (avs_readdata !== 32'h0) $display("[TB] FAIL edge_before_lat3: got %h want 0", avs_readdata); else passed++;
        total++; if (irq !== 1'b0) $display("[TB] FAIL irq_at_lat3: got %b want 0", irq); else passed++;
        tick();
        avs_read = 1'b0;
        total++; if (avs_readdata !== 32'h1) $display("[TB] FAIL edge_lat3: got %h want 1", avs_readdata); else passed++;
        total++; if (irq !== 1'b1) $display("[TB] FAIL irq_lat4: got %b want 1", irq); else passed++;
        bus_write(5'h18, 32'h1);
        tick();
        total++; if (irq !== 1'b0) $display("[TB] FAIL irq_clear: got %b want 0", irq); else passed++;
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL edge_cleared: got %h want 0", d); else passed++;
    endtask

    task automatic test_fall_only;
        logic [31:0] d; logic v;
        bus_write(5'h1F, 32'h0);
        in_port[0] = 1'b0;
        repeat (5) tick();
        bus_write(5'h1F, 32'h2);
        in_port[0] = 1'b1;
        repeat (5) tick();
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL fall_only_rise: got %h want 0", d); else passed++;
        in_port[0] = 1'b0;
        repeat (5) tick();
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h1) $display("[TB] FAIL fall_only_fall: got %h want 1", d); else passed++;
        total++; if (irq !== 1'b1) $display("[TB] FAIL fall_irq: got %b want 1", irq); else passed++;
        bus_write(5'h18, 32'hFFFF_FFFF);
    endtask

    task automatic test_set_wins;
        logic [31:0] d; logic v;
        bus_write(5'h1F, 32'h1);
        in_port[1] = 1'b1;
        repeat (5) tick();
        in_port[0] = 1'b1;
        tick(); tick();
        bus_write(5'h18, 32'h3);
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h1) $display("[TB] FAIL set_wins: got %h want 1", d); else passed++;
        in_port = '0;
        repeat (5) tick();
        bus_write(5'h18, 32'hFFFF_FFFF);
    endtask

    // Model: IN is the applied input delayed by two clocks; edges come from successive IN values.
    task automatic test_random_edges;
        logic [31:0] d; logic v;
        logic [NI*DW-1:0] hist [$];
        logic [31:0] m_in [NI], m_prev [NI], m_edge [NI], m_mask [NI], clr [NI], s;
        logic rise, fall, irq_exp;
        logic [1:0] ctl;
        int ch;
        in_port = {$urandom, $urandom};
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        for (int i = 0; i < NO; i++) m_out[i] = '0;
        repeat (4) tick();
        ctl = 2'($urandom_range(1, 3));
        rise = ctl[0]; fall = ctl[1];
        for (int i = 0; i < NI; i++) begin
            m_mask[i] = $urandom; bus_write(5'h14 + 5'(i), m_mask[i]);
            m_in[i] = in_port[i*DW +: DW]; m_prev[i] = m_in[i]; m_edge[i] = '0;
        end
        bus_write(5'h1F, {30'h0, ctl});
        hist.push_back(in_port); hist.push_back(in_port);
        for (int n = 0; n < 203; n++) begin
            for (int i = 0; i < NI; i++) clr[i] = '0;
            if (n < 200 && $urandom_range(0, 1) == 0) in_port = {$urandom, $urandom};
            if (n < 200 && $urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, NI-1);
                clr[ch] = $urandom;
                avs_address = 5'h18 + 5'(ch); avs_writedata = clr[ch]; avs_write = 1'b1;
            end
            irq_exp = 1'b0;
            for (int i = 0; i < NI; i++) irq_exp = irq_exp | (|(m_edge[i] & m_mask[i]));
            hist.push_back(in_port);
            tick();
            avs_write = 1'b0;
            for (int i = 0; i < NI; i++) begin
                s = (rise ? (m_in[i] & ~m_prev[i]) : 32'h0) | (fall ? (~m_in[i] & m_prev[i]) : 32'h0);
                m_edge[i] = (m_edge[i] & ~clr[i]) | s;
                m_prev[i] = m_in[i];
                m_in[i]   = hist[hist.size()-2][i*DW +: DW];
            end
            if (hist.size() > 4) void'(hist.pop_front());
            total++; if (irq !== irq_exp) $display("[TB] FAIL rand_irq cycle %0d: got %b want %b", n, irq, irq_exp); else passed++;
        end
        for (int i = 0; i < NI; i++) begin
            bus_read(5'h18 + 5'(i), d, v);
            total++; if (d !== m_edge[i]) $display("[TB] FAIL rand_edge%0d: got %h want %h", i, d, m_edge[i]); else passed++;
            bus_read(5'h10 + 5'(i), d, v);
            total++; if (d !== m_in[i]) $display("[TB] FAIL rand_in%0d: got %h want %h", i, d, m_in[i]); else passed++;
        end
    endtask

    task automatic test_debounce;
        logic [31:0] d; logic v;
        reset = 1'b1; in_port = '0; tick(); tick(); reset = 1'b0; tick();
        bus_write(5'h1F, 32'h1);
        bus_write(5'h14, 32'h1);
        in_port[0] = 1'b1;
        repeat (5) tick();
        in_port[0] = 1'b0;
        repeat (20) tick();
        bus_read(5'h10, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL deb_glitch_in: got %h want 0", d); else passed++;
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL deb_glitch_edge: got %h want 0", d); else passed++;
        in_port[0] = 1'b1;
        repeat (20) tick();
        bus_read(5'h10, d, v);
        total++; if (d !== 32'h1) $display("[TB] FAIL deb_hold_in: got %h want 1", d); else passed++;
        bus_read(5'h18, d, v);
        total++; if (d !== 32'h1) $display("[TB] FAIL deb_hold_edge: got %h want 1", d); else passed++;
        total++; if (irq !== 1'b1) $display("[TB] FAIL deb_irq: got %b want 1", irq); else passed++;
        in_port[0] = 1'b0;
        repeat (20) tick();
        in_port[0] = 1'b1;
        repeat (6) tick();
        reset = 1'b1; in_port[0] = 1'b0;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        bus_read(5'h10, d, v);
        total++; if (d !== 32'h0) $display("[TB] FAIL deb_reset_in: got %h want 0", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_out_regs();
        test_back_to_back();
        test_unmapped();
        test_rw_collision();
        test_mask_ctrl();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`else
        test_rise_irq();
        test_fall_only();
        test_set_wins();
        test_random_edges();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
